// File: rtl/riscv_instr_encoder.sv
// Streaming RV32IM instruction encoder: symbolic request -> 32-bit word, with LI
// expansion into LUI/ADDI and a small circular output FIFO.
module riscv_instr_encoder #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [5:0]                    req_op_i,
  input  logic [4:0]                    req_rd_i,
  input  logic [4:0]                    req_rs1_i,
  input  logic [4:0]                    req_rs2_i,
  input  logic [31:0]                   req_imm_i,
  output logic                          instr_valid_o,
  input  logic                          instr_ready_i,
  output logic [31:0]                   instr_rdata_o,
  output logic                          err_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_EMIT2} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0] r_cnt;
  logic [31:0] r_pend;
  logic        r_err;

  logic        w_full, w_empty, w_accept, w_push, w_pop;
  logic [31:0] w_push_data, w_word, w_word2;
  logic        w_illegal, w_two;
  logic        w_i_ok, w_sh_ok, w_b_ok, w_j_ok, w_u_ok;
  logic [19:0] w_li_hi;
  logic [2:0]  w_f3, w_mrel;

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  assign w_i_ok  = (req_imm_i[31:11] == '0) || (req_imm_i[31:11] == '1);
  assign w_sh_ok = (req_imm_i[31:5] == '0);
  assign w_b_ok  = !req_imm_i[0] && ((req_imm_i[31:12] == '0) || (req_imm_i[31:12] == '1));
  assign w_j_ok  = !req_imm_i[0] && ((req_imm_i[31:20] == '0) || (req_imm_i[31:20] == '1));
  assign w_u_ok  = (req_imm_i[31:20] == '0);
  // Rounded upper part so that LUI + sign-extended ADDI reconstructs the value.
  assign w_li_hi = 20'((req_imm_i + 32'h0000_0800) >> 12);
  assign w_mrel  = 3'(req_op_i - 6'd29);

  always_comb begin
    w_f3 = '0;
    case (req_op_i)
      6'd4, 6'd10, 6'd19, 6'd20:               w_f3 = 3'd0;
      6'd5, 6'd16, 6'd21:                      w_f3 = 3'd1;
      6'd11, 6'd22:                            w_f3 = 3'd2;
      6'd12, 6'd23:                            w_f3 = 3'd3;
      6'd6, 6'd13, 6'd24:                      w_f3 = 3'd4;
      6'd7, 6'd17, 6'd18, 6'd25, 6'd26:        w_f3 = 3'd5;
      6'd8, 6'd14, 6'd27:                      w_f3 = 3'd6;
      6'd9, 6'd15, 6'd28:                      w_f3 = 3'd7;
      default:                                 w_f3 = 3'd0;
    endcase
  end

  always_comb begin
    w_word    = '0;
    w_word2   = '0;
    w_illegal = 1'b0;
    w_two     = 1'b0;
    case (req_op_i) inside
      6'd0: begin
        w_word    = {req_imm_i[19:0], req_rd_i, 7'h37};
        w_illegal = !w_u_ok;
      end
      6'd1: begin
        w_word    = {req_imm_i[19:0], req_rd_i, 7'h17};
        w_illegal = !w_u_ok;
      end
      6'd2: begin
        w_word    = {req_imm_i[20], req_imm_i[10:1], req_imm_i[11], req_imm_i[19:12],
                     req_rd_i, 7'h6F};
        w_illegal = !w_j_ok;
      end
      6'd3: begin
        w_word    = enc_i(req_imm_i[11:0], req_rs1_i, 3'd0, req_rd_i, 7'h67);
        w_illegal = !w_i_ok;
      end
      [6'd4:6'd9]: begin
        w_word    = {req_imm_i[12], req_imm_i[10:5], req_rs2_i, req_rs1_i, w_f3,
                     req_imm_i[4:1], req_imm_i[11], 7'h63};
        w_illegal = !w_b_ok;
      end
      [6'd10:6'd15]: begin
        w_word    = enc_i(req_imm_i[11:0], req_rs1_i, w_f3, req_rd_i, 7'h13);
        w_illegal = !w_i_ok;
      end
      [6'd16:6'd18]: begin
        w_word    = enc_r((req_op_i == 6'd18) ? 7'h20 : 7'h00, req_imm_i[4:0], req_rs1_i,
                          w_f3, req_rd_i, 7'h13);
        w_illegal = !w_sh_ok;
      end
      [6'd19:6'd28]: begin
        w_word = enc_r((req_op_i == 6'd20 || req_op_i == 6'd26) ? 7'h20 : 7'h00,
                       req_rs2_i, req_rs1_i, w_f3, req_rd_i, 7'h33);
      end
      [6'd29:6'd36]: w_word = enc_r(7'h01, req_rs2_i, req_rs1_i, w_mrel, req_rd_i, 7'h33);
      6'd37: w_word = 32'h0000_0073;
      6'd38: w_word = 32'h0010_0073;
      6'd39: w_word = 32'h3020_0073;
      6'd40: w_word = 32'h1050_0073;
      6'd41: w_word = 32'h0000_100F;
      6'd42: begin
        if (w_i_ok) begin
          w_word = enc_i(req_imm_i[11:0], 5'd0, 3'd0, req_rd_i, 7'h13);
        end else begin
          w_word  = {w_li_hi, req_rd_i, 7'h37};
          w_two   = (req_imm_i[11:0] != '0);
          w_word2 = enc_i(req_imm_i[11:0], req_rd_i, 3'd0, req_rd_i, 7'h13);
        end
      end
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_full      = (r_cnt == (AW+1)'(FIFO_DEPTH));
  assign w_empty     = (r_cnt == '0);
  assign req_ready_o = (r_state == S_IDLE) && !w_full;
  assign w_accept    = req_valid_i && req_ready_o;
  assign w_push      = (r_state == S_IDLE) ? (w_accept && !w_illegal) : !w_full;
  assign w_push_data = (r_state == S_EMIT2) ? r_pend : w_word;
  assign w_pop       = !w_empty && instr_ready_i;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && !w_illegal && w_two) w_state_nxt = S_EMIT2;
      S_EMIT2: if (!w_full) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pend  <= '0;
      r_err   <= 1'b0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_accept && w_illegal;
      if (r_state == S_IDLE && w_accept && !w_illegal && w_two) r_pend <= w_word2;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_push_data;
  end

  assign instr_valid_o = !w_empty;
  assign instr_rdata_o = w_empty ? '0 : r_mem[r_rptr];
  assign err_o         = r_err;
  assign fifo_cnt_o    = r_cnt;

endmodule

// File: tb/tb_riscv_instr_encoder.sv
// Scoreboard bench for riscv_instr_encoder: directed cases plus random requests
// checked against an arithmetic encoding model.
module tb_riscv_instr_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [5:0]  req_op_i = '0;
  logic [4:0]  req_rd_i = '0, req_rs1_i = '0, req_rs2_i = '0;
  logic [31:0] req_imm_i = '0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] instr_rdata_o;
  logic        err_o;
  logic [2:0]  fifo_cnt_o;

  riscv_instr_encoder #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_rd_i(req_rd_i), .req_rs1_i(req_rs1_i),
    .req_rs2_i(req_rs2_i), .req_imm_i(req_imm_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_rdata_o(instr_rdata_o), .err_o(err_o), .fifo_cnt_o(fifo_cnt_o)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0, n_fail = 0;
  int          ncyc = 0;
  bit          rnd_ready = 1'b0;
  logic [31:0] exp_q[$];
  int          err_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] itype(input int unsigned imm, input int unsigned rs1,
                                        input int unsigned f3, input int unsigned rd,
                                        input int unsigned opc);
    return ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | opc;
  endfunction

  function automatic logic [31:0] rtype(input int unsigned f7, input int unsigned rs2,
                                        input int unsigned rs1, input int unsigned f3,
                                        input int unsigned rd, input int unsigned opc);
    return (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | opc;
  endfunction

  // Pushes the expected words of a request; returns 1 if the request is illegal.
  function automatic bit model(input int unsigned op, input int unsigned rd,
                               input int unsigned rs1, input int unsigned rs2,
                               input logic [31:0] imm);
    int unsigned u = imm;
    longint      s = longint'($signed(imm));
    int unsigned br_f3[6] = '{0, 1, 4, 5, 6, 7};
    int unsigned al_f3[6] = '{0, 2, 3, 4, 6, 7};
    int unsigned r_f3[10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
    int unsigned r_f7[10] = '{0, 32, 0, 0, 0, 0, 0, 32, 0, 0};
    logic [31:0] fixed[5] = '{32'h00000073, 32'h00100073, 32'h30200073,
                              32'h10500073, 32'h0000100F};
    int unsigned hi, lo;
    if (op <= 1) begin
      if (u > 32'hFFFFF) return 1'b1;
      exp_q.push_back((u << 12) | (rd << 7) | ((op == 0) ? 32'h37 : 32'h17));
    end else if (op == 2) begin
      if ((u & 1) != 0 || s < -(64'sd1 << 20) || s > (64'sd1 << 20) - 2) return 1'b1;
      exp_q.push_back((((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21) |
                      (((u >> 11) & 1) << 20) | (((u >> 12) & 32'hFF) << 12) |
                      (rd << 7) | 32'h6F);
    end else if (op == 3) begin
      if (s < -2048 || s > 2047) return 1'b1;
      exp_q.push_back(itype(u, rs1, 0, rd, 32'h67));
    end else if (op <= 9) begin
      if ((u & 1) != 0 || s < -4096 || s > 4094) return 1'b1;
      exp_q.push_back((((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) |
                      (rs2 << 20) | (rs1 << 15) | (br_f3[op-4] << 12) |
                      (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 1) << 7) | 32'h63);
    end else if (op <= 15) begin
      if (s < -2048 || s > 2047) return 1'b1;
      exp_q.push_back(itype(u, rs1, al_f3[op-10], rd, 32'h13));
    end else if (op <= 18) begin
      if (s < 0 || s > 31) return 1'b1;
      exp_q.push_back(rtype((op == 18) ? 32 : 0, u, rs1, (op == 16) ? 1 : 5, rd, 32'h13));
    end else if (op <= 28) begin
      exp_q.push_back(rtype(r_f7[op-19], rs2, rs1, r_f3[op-19], rd, 32'h33));
    end else if (op <= 36) begin
      exp_q.push_back(rtype(1, rs2, rs1, op - 29, rd, 32'h33));
    end else if (op <= 41) begin
      exp_q.push_back(fixed[op-37]);
    end else if (op == 42) begin
      if (s >= -2048 && s <= 2047) begin
        exp_q.push_back(itype(u, 0, 0, rd, 32'h13));
      end else begin
        hi = ((u + 32'h800) >> 12) & 32'hFFFFF;
        lo = u & 32'hFFF;
        exp_q.push_back((hi << 12) | (rd << 7) | 32'h37);
        if (lo != 0) exp_q.push_back(itype(lo, rd, 0, rd, 32'h13));
      end
    end else begin
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
  task automatic send(input int unsigned op, input int unsigned rd, input int unsigned rs1,
                      input int unsigned rs2, input logic [31:0] imm);
    int unsigned w = 0;
    req_valid_i = 1'b1;
    req_op_i = 6'(op); req_rd_i = 5'(rd); req_rs1_i = 5'(rs1); req_rs2_i = 5'(rs2);
    req_imm_i = imm;
    @(negedge clk);
    while (!req_ready_o && w < 300) begin
      w++;
      @(negedge clk);
    end
    if (!req_ready_o) begin
      check("req_ready_timeout", 32'(req_ready_o), 32'd1);
      req_valid_i = 1'b0;
      return;
    end
    @(posedge clk);
    if (model(op, rd, rs1, rs2, imm)) err_q.push_back(ncyc + 1);
    #1;
    req_valid_i = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int unsigned w = 0;
    rnd_ready = 1'b0;
    instr_ready_i = 1'b1;
    while ((exp_q.size() != 0 || fifo_cnt_o != 0) && w < 200) begin
      w++;
      cycles(1);
    end
    check("drain_remaining", 32'(exp_q.size()) + 32'(fifo_cnt_o), 32'd0);
    cycles(2);
  endtask

  task automatic pop_one();
    instr_ready_i = 1'b1;
    cycles(1);
    instr_ready_i = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever the DUT hands over a word.
  always @(negedge clk) begin
    logic [31:0] e;
    bit exp_err;
    ncyc++;
    if (!rst) begin
      if (instr_valid_o && instr_ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", instr_rdata_o, 32'hxxxxxxxx);
        end else begin
          e = exp_q.pop_front();
          check("instr_word", instr_rdata_o, e);
        end
      end
      exp_err = (err_q.size() != 0) && (err_q[0] == ncyc);
      if (exp_err) void'(err_q.pop_front());
      if (err_o || exp_err) check("err_pulse", 32'(err_o), 32'(exp_err));
    end
  end

  always @(posedge clk) begin
    #2;
    if (rnd_ready) instr_ready_i = 1'($urandom_range(0, 1));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned op;
    logic [31:0] imm;
    #3;
    check("rst_valid", 32'(instr_valid_o), 32'd0);
    check("rst_cnt", 32'(fifo_cnt_o), 32'd0);
    check("rst_rdata", instr_rdata_o, 32'd0);
    #20 rst = 1'b0;
    cycles(2);
    check("rst_ready", 32'(req_ready_o), 32'd1);
    check("rst_err", 32'(err_o), 32'd0);

    // Single-word encodes
    instr_ready_i = 1'b1;
    send(10, 1, 0, 0, 32'd5);
    check("addi_valid", 32'(instr_valid_o), 32'd1);
    check("addi_cnt1", 32'(fifo_cnt_o), 32'd1);
    check("addi_word", instr_rdata_o, 32'h00500093);
    cycles(1);
    check("addi_cnt0", 32'(fifo_cnt_o), 32'd0);
    send(19, 3, 1, 2, 32'd0);
    check("add_word", instr_rdata_o, 32'h002081B3);
    send(39, 0, 0, 0, 32'd0);
    check("mret_word", instr_rdata_o, 32'h30200073);
    drain();

    // LI expansion
    send(42, 5, 0, 0, 32'h12345678);
    check("li_emit2_ready", 32'(req_ready_o), 32'd0);
    check("li_lui", instr_rdata_o, 32'h123452B7);
    cycles(1);
    check("li_addi", instr_rdata_o, 32'h67828293);
    send(42, 5, 0, 0, 32'h00000800);
    check("li800_lui", instr_rdata_o, 32'h000012B7);
    cycles(1);
    check("li800_addi", instr_rdata_o, 32'h80028293);
    send(42, 5, 0, 0, 32'h00010000);
    check("li10000_ready", 32'(req_ready_o), 32'd1);
    check("li10000_lui", instr_rdata_o, 32'h000102B7);
    send(42, 5, 0, 0, 32'hFFFFFFFF);
    check("li_m1", instr_rdata_o, 32'hFFF00293);
    drain();

    // Illegal requests leave the FIFO untouched
    instr_ready_i = 1'b0;
    send(10, 2, 0, 0, 32'd7);
    send(4, 0, 1, 2, 32'd3);
    check("ill_beq_cnt", 32'(fifo_cnt_o), 32'd1);
    send(10, 1, 0, 0, 32'd2048);
    check("ill_addi_cnt", 32'(fifo_cnt_o), 32'd1);
    send(16, 1, 1, 0, 32'd32);
    check("ill_slli_cnt", 32'(fifo_cnt_o), 32'd1);
    send(50, 1, 1, 1, 32'd0);
    check("ill_op_cnt", 32'(fifo_cnt_o), 32'd1);
    cycles(2);
    drain();

    // FIFO full, backpressure, wrap
    instr_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) send(10, i + 1, 0, 0, 32'(i + 100));
    check("full_cnt", 32'(fifo_cnt_o), 32'd4);
    check("full_ready", 32'(req_ready_o), 32'd0);
    cycles(5);
    check("full_ready_hold", 32'(req_ready_o), 32'd0);
    pop_one();
    check("pop_reenable", 32'(req_ready_o), 32'd1);
    rnd_ready = 1'b1;
    for (int i = 0; i < 10; i++) send(10, 7, 3, 0, 32'(i * 37 - 150));
    drain();

    // EMIT2 stall on a full FIFO
    instr_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) send(11, 4, 2, 0, 32'(i));
    send(42, 5, 0, 0, 32'h12345678);
    check("stall_cnt", 32'(fifo_cnt_o), 32'd4);
    cycles(3);
    check("stall_hold_cnt", 32'(fifo_cnt_o), 32'd4);
    check("stall_ready", 32'(req_ready_o), 32'd0);
    pop_one();
    check("stall_after_pop", 32'(fifo_cnt_o), 32'd3);
    cycles(1);
    check("stall_addi_pushed", 32'(fifo_cnt_o), 32'd4);
    drain();

    // Reset while in EMIT2
    instr_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) send(13, 6, 1, 0, 32'(i + 9));
    send(42, 5, 0, 0, 32'h12345678);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(instr_valid_o), 32'd0);
    check("mid_rst_cnt", 32'(fifo_cnt_o), 32'd0);
    check("mid_rst_rdata", instr_rdata_o, 32'd0);
    exp_q.delete();
    err_q.delete();
    cycles(2);
    #3 rst = 1'b0;
    cycles(1);
    check("post_rst_ready", 32'(req_ready_o), 32'd1);
    instr_ready_i = 1'b1;
    send(10, 1, 0, 0, 32'd5);
    check("post_rst_addi", instr_rdata_o, 32'h00500093);
    drain();

    // Random traffic
    rnd_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      op = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 42) : $urandom_range(43, 63);
      case ($urandom_range(0, 4))
        0:       imm = 32'(int'($urandom_range(0, 4095)) - 2048);
        1:       imm = 32'($urandom_range(0, 40));
        2:       imm = 32'(int'($urandom_range(0, 8191)) - 4096);
        3:       imm = 32'(int'($urandom_range(0, 32'h3FFFFF)) - 32'h200000);
        default: imm = $urandom;
      endcase
      send(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), imm);
    end
    drain();
    check("err_q_empty", 32'(err_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_instr_encoder.md
# riscv_instr_encoder

Streaming RV32IM instruction encoder: accepts symbolic requests (operation ID, register indices, immediate) and produces 32-bit instruction words whose bit patterns match the core's tracer masks and `riscv_defines` opcodes. Sits in the verification/boot infrastructure next to the core, feeding an instruction memory preloader or a directed-stimulus injector. Buffers results in a small output FIFO. Expands the `LI` pseudo-op into `LUI`/`ADDI` over multiple cycles.

## Interface
- `FIFO_DEPTH`, 4: output FIFO entries; power of two, at least 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid_i`  in  1  request valid.
- `req_ready_o`  out  1  request accepted when `req_valid_i && req_ready_o` at a rising edge.
- `req_op_i`  in  6  operation ID (see Operation).
- `req_rd_i`, `req_rs1_i`, `req_rs2_i`  in  5 each  register indices.
- `req_imm_i`  in  32  immediate value, signed unless stated otherwise.
- `instr_valid_o`  out  1  FIFO head valid.
- `instr_ready_i`  in  1  consumer pops the head when `instr_valid_o && instr_ready_i`.
- `instr_rdata_o`  out  32  FIFO head word.
- `err_o`  out  1  one-cycle pulse: the accepted request was illegal and emitted nothing.
- `fifo_cnt_o`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- **Op IDs:**
  - 0 LUI, 1 AUIPC, 2 JAL, 3 JALR.
  - 4–9: BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - 10–15: ADDI, SLTI, SLTIU, XORI, ORI, ANDI.
  - 16–18: SLLI, SRLI, SRAI.
  - 19–28: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - 29–36: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - 37 ECALL, 38 EBREAK, 39 MRET, 40 WFI, 41 FENCE.I, 42 LI.
  - 43–63 are illegal.
- **Encoding:** standard RV32 field placement (funct7/funct3/opcode as in the tracer masks). Fields the format does not use are zero, e.g. rs2 for I-type, rd/rs1 for SYSTEM. Fixed words:
  - ECALL = 0x00000073, EBREAK = 0x00100073, MRET = 0x30200073, WFI = 0x10500073, FENCE.I = 0x0000100F.
- **Legality checks** (a failure raises `err_o`; nothing is pushed):
  - I-type imm in [-2048, 2047].
  - Shift imm in [0, 31].
  - Branch imm even, in [-4096, 4094].
  - JAL imm even, in [-2^20, 2^20-2].
  - LUI/AUIPC imm (20-bit upper value) in [0, 0xFFFFF].
  - Op ID must be in 0–42.
- **LI rd, imm:**
  - If imm is in [-2048, 2047]: emit a single `ADDI rd, x0, imm`.
  - Otherwise: hi = (imm + 0x800) >> 12 (logical, 20 bits) and lo = imm[11:0]. Emit `LUI rd, hi`, then `ADDI rd, rd, lo` only if lo != 0.
  - LI is never illegal.
- **FSM: IDLE, EMIT2.**
  - IDLE: `req_ready_o` = FIFO not full.
  - On accepting an LI that needs two words: push LUI and go to EMIT2.
  - EMIT2: `req_ready_o` = 0. The ADDI is held internally and pushed on the first cycle the FIFO is not full; then return to IDLE.
- **FIFO:**
  - Circular buffer with wrapping read/write pointers.
  - Push and pop in the same cycle is allowed whenever not empty; occupancy is unchanged.
  - There is no full-bypass: `req_ready_o` depends only on the pre-edge occupancy, never on `instr_ready_i`.
- **Reset** (asynchronous, takes effect immediately):
  - FSM → IDLE; FIFO emptied.
  - `instr_valid_o` = 0, `instr_rdata_o` = 0, `err_o` = 0, `fifo_cnt_o` = 0, `req_ready_o` = 1 after release.
  - A pending EMIT2 word is discarded.

## Timing
- **Latency:** a request accepted at edge N has its word in the FIFO after edge N. `instr_valid_o` is high in cycle N+1 if the FIFO was empty.
- **Two-word LI:** LUI is pushed at edge N. ADDI is pushed at edge N+1 if space is available (otherwise later), so it appears at the head no earlier than cycle N+2. The next request can be accepted no earlier than edge N+2.
- **`err_o`:** high in exactly cycle N+1 for an illegal request accepted at edge N. The FIFO is unaffected.
- **`instr_rdata_o`:** when empty, holds 0. When valid, stable until popped.
- **Backpressure:** with the FIFO full and `instr_ready_i` = 0, `req_ready_o` = 0 indefinitely. The first pop re-enables it on the following cycle.

## Test plan
- **Single-word encodes:** ADDI x1,x0,5 → 0x00500093; ADD x3,x1,x2 → 0x002081B3; MRET → 0x30200073. Each appears one cycle after acceptance; `fifo_cnt_o` goes 0→1→0 with `instr_ready_i` = 1.
- **LI expansion:**
  - LI x5,0x12345678 → 0x123452B7, then 0x67828293.
  - LI x5,0x800 → 0x000012B7, then 0x80028293.
  - LI x5,0x10000 → only 0x000102B7.
  - LI x5,-1 → only 0xFFF00293.
  - `req_ready_o` is low during EMIT2.
- **Illegal requests:** BEQ x1,x2,imm=3; ADDI imm=2048; SLLI imm=32; op=50. Each gives an `err_o` one-cycle pulse, `fifo_cnt_o` unchanged, and no output word.
- **FIFO full/wrap:** hold `instr_ready_i` = 0 and push 4 ADDIs → `fifo_cnt_o` = 4 and `req_ready_o` = 0. Then pop and push 10 more with concurrent pops → order preserved across pointer wrap, no loss or duplication.
- **EMIT2 stall:** fill the FIFO to 3, then request LI x5,0x12345678 → LUI fills the FIFO and the FSM stays in EMIT2. One pop → the ADDI is pushed the next edge and the FSM returns to IDLE.
- **Reset mid-operation:** assert `rst` while in EMIT2 with 3 entries queued → `instr_valid_o` = 0 and `fifo_cnt_o` = 0 immediately. After release, the pending ADDI never appears and the next ADDI x1,x0,5 gives 0x00500093.
